drum_tone_arbiter: RTL

//  Shares one square-wave tone generator between four drum-pad requesters.

---
 rtl/drum_tone_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/drum_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drum_tone_arbiter
// Purpose  : Shares one square-wave tone generator between four drum-pad
//            requesters. A round-robin arbiter picks one pad. That pad's tone
//            (16-bit samples alternating AMP / 0) plays for DUR_CYCLES.
//            A silent gap of GAP_CYCLES follows, and then the block
//            arbitrates again.
// Ports    : clk    - system clock, all state updates on the rising edge
//            reset  - asynchronous, active-low reset
//            enable - 1 allows grants; 0 during a tone aborts it
//            req    - per-pad request levels (held by requester until granted)
//            sample - audio sample to the DAC path
//            grant  - one-hot, one-cycle pulse naming the pad just accepted
//            cur_ch - channel playing or last played
//            busy   - high while playing a tone or in the silent gap
//            done   - one-cycle pulse when a tone completes its full duration
// Revision : 1.0 - initial release
// ============================================================================
module drum_tone_arbiter #(
    parameter int HALF_P0    = 40,
    parameter int HALF_P1    = 50,
    parameter int HALF_P2    = 60,
    parameter int HALF_P3    = 80,
    parameter int DUR_CYCLES = 4000,
    parameter int GAP_CYCLES = 100,
    parameter int AMP        = 8191
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  req,
    output logic [15:0] sample,
    output logic [3:0]  grant,
    output logic [1:0]  cur_ch,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [15:0] c_amp        = 16'(AMP);
    localparam logic [15:0] c_dur_last   = 16'(DUR_CYCLES - 1);
    localparam logic [15:0] c_gap_last   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] c_half_last0 = 16'(HALF_P0 - 1);
    localparam logic [15:0] c_half_last1 = 16'(HALF_P1 - 1);
    localparam logic [15:0] c_half_last2 = 16'(HALF_P2 - 1);
    localparam logic [15:0] c_half_last3 = 16'(HALF_P3 - 1);

    logic [1:0]  r_state,    w_state;
    logic [1:0]  r_rr_ptr,   w_rr_ptr;
    logic [15:0] r_half_cnt, w_half_cnt;
    logic [15:0] r_dur_cnt,  w_dur_cnt;
    logic [15:0] r_gap_cnt,  w_gap_cnt;
    logic [15:0] r_sample,   w_sample;
    logic [3:0]  r_grant,    w_grant;
    logic [1:0]  r_cur_ch,   w_cur_ch;
    logic        r_busy,     w_busy;
    logic        r_done,     w_done;

    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_win;
    logic [15:0] w_half_last;

    // Rotate the request vector so bit 0 is the pad at the round-robin
    // pointer; the first set bit then gives the winner's offset from it.
    always_comb begin
        w_rot = req;
        case (r_rr_ptr)
            2'd0:    w_rot = req;
            2'd1:    w_rot = {req[0],   req[3:1]};
            2'd2:    w_rot = {req[1:0], req[3:2]};
            default: w_rot = {req[2:0], req[3]};
        endcase
    end

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    // Two-bit addition wraps modulo 4, matching the pad ring.
    assign w_win = r_rr_ptr + w_off;

    always_comb begin
        w_half_last = c_half_last0;
        case (r_cur_ch)
            2'd0:    w_half_last = c_half_last0;
            2'd1:    w_half_last = c_half_last1;
            2'd2:    w_half_last = c_half_last2;
            default: w_half_last = c_half_last3;
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_rr_ptr   = r_rr_ptr;
        w_half_cnt = r_half_cnt;
        w_dur_cnt  = r_dur_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_sample   = r_sample;
        w_grant    = 4'b0000;
        w_cur_ch   = r_cur_ch;
        w_busy     = r_busy;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sample = 16'd0;
                w_busy   = 1'b0;
                if (enable && (|req)) begin
                    w_grant    = 4'b0001 << w_win;
                    w_cur_ch   = w_win;
                    w_busy     = 1'b1;
                    w_sample   = c_amp;
                    w_half_cnt = 16'd0;
                    w_dur_cnt  = 16'd0;
                    w_rr_ptr   = w_win + 2'd1;
                    w_state    = S_PLAY;
                end
            end

            S_PLAY: begin
                if (!enable) begin
                    // Abort: silence at once, no completion pulse.
                    w_sample  = 16'd0;
                    w_gap_cnt = 16'd0;
                    w_state   = S_GAP;
                end else if (r_dur_cnt == c_dur_last) begin
                    // Duration end takes precedence over a coincident toggle.
                    w_sample  = 16'd0;
                    w_done    = 1'b1;
                    w_gap_cnt = 16'd0;
                    w_state   = S_GAP;
                end else begin
                    w_dur_cnt = r_dur_cnt + 16'd1;
                    if (r_half_cnt == w_half_last) begin
                        w_sample   = (r_sample == 16'd0) ? c_amp : 16'd0;
                        w_half_cnt = 16'd0;
                    end else begin
                        w_half_cnt = r_half_cnt + 16'd1;
                    end
                end
            end

            S_GAP: begin
                w_sample = 16'd0;
                w_busy   = 1'b1;
                if (r_gap_cnt == c_gap_last) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + 16'd1;
                end
            end

            default: begin
                w_sample = 16'd0;
                w_busy   = 1'b0;
                w_state  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 2'd0;
            r_half_cnt <= 16'd0;
            r_dur_cnt  <= 16'd0;
            r_gap_cnt  <= 16'd0;
            r_sample   <= 16'd0;
            r_grant    <= 4'b0000;
            r_cur_ch   <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rr_ptr   <= w_rr_ptr;
            r_half_cnt <= w_half_cnt;
            r_dur_cnt  <= w_dur_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_sample   <= w_sample;
            r_grant    <= w_grant;
            r_cur_ch   <= w_cur_ch;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign sample = r_sample;
    assign grant  = r_grant;
    assign cur_ch = r_cur_ch;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
